// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, reset vector, bench vectors and PC operation codes
package pc_pkg;
    localparam int          ADDR_W_DEF       = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
    localparam logic [15:0] VEC_A            = 16'hFDA9;
    localparam logic [15:0] VEC_B            = 16'hFB53;
    localparam logic [2:0]  OP_HOLD          = 3'd0;
    localparam logic [2:0]  OP_PEND          = 3'd1;
    localparam logic [2:0]  OP_INT           = 3'd2;
    localparam logic [2:0]  OP_RET           = 3'd3;
    localparam logic [2:0]  OP_SET           = 3'd4;
    localparam logic [2:0]  OP_INC           = 3'd5;
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int W     = ADDR_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_overflow,
    output logic         o_underflow
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, top_idx;
    logic [PW:0]   cnt_q, cnt_d;

    assign top_idx     = ptr_q - PW'(1);
    assign o_data      = mem_q[top_idx];
    assign o_empty     = cnt_q == '0;
    assign o_full      = cnt_q == (PW+1)'(DEPTH);
    assign o_overflow  = i_push && o_full;
    assign o_underflow = i_pop && o_empty;

    // next pointer/count; the write slot wraps so the oldest entry is lost on overflow
    always_comb begin
        mem_d = mem_q;
        if (i_push) mem_d[ptr_q] = i_data;
        ptr_d = i_push ? ptr_q + PW'(1) : (i_pop && !o_empty) ? top_idx : ptr_q;
        cnt_d = (i_push && !o_full) ? cnt_q + (PW+1)'(1) : (i_pop && !o_empty) ? cnt_q - (PW+1)'(1) : cnt_q;
    end

    // storage needs no reset: the count alone says which entries are valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/program_counter.sv
// program_counter: PC sequencer with interrupt entry, return stack and bus drive; PC_BRANCH_TRACE_EN adds branch trace outputs
module program_counter
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STEP         = 1,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_set_enable,
    input  logic              i_address_enable,
    input  logic              i_lock,
    input  logic              i_interrupt,
    input  logic              i_ret,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic              o_addr_oe,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_stack_empty,
    output logic              o_stack_full,
`ifdef PC_BRANCH_TRACE_EN
    output logic [ADDR_W-1:0] o_trace_src,
    output logic [ADDR_W-1:0] o_trace_dst,
`endif
    output logic              o_fault
);
    logic [2:0]        op;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_vec_q, pend_vec_d, pop_data;
    logic              pend_q, pend_d, fault_q, fault_d;
    logic              push, pop, ovf, unf, lock_int;

    assign lock_int   = i_lock && i_interrupt;
    assign o_pc       = pc_q;
    assign o_addr_oe  = i_address_enable;
    assign o_addr_bus = i_address_enable ? pc_q : '0;
    assign o_fault    = fault_q;

    // pick the single winning operation this cycle in strobe priority order
    always_comb begin
        op = i_lock ? OP_HOLD : pend_q ? OP_PEND : i_interrupt ? OP_INT :
             i_ret ? OP_RET : i_set_enable ? OP_SET : i_advance ? OP_INC : OP_HOLD;
    end

    // next PC, pending interrupt and sticky fault; the pushed value is the current PC
    always_comb begin
        push       = (op == OP_PEND) || (op == OP_INT);
        pop        = op == OP_RET;
        pc_d       = (op == OP_PEND) ? pend_vec_q :
                     (op == OP_INT || op == OP_SET) ? i_load_addr :
                     (op == OP_RET) ? (o_stack_empty ? RESET_VECTOR : pop_data) :
                     (op == OP_INC) ? pc_q + STEP : pc_q;
        pend_d     = lock_int ? 1'b1 : (op == OP_PEND) ? 1'b0 : pend_q;
        pend_vec_d = lock_int ? i_load_addr : pend_vec_q;
        fault_d    = fault_q || ovf || unf;
    end

    // PC, pending-interrupt and fault registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q       <= RESET_VECTOR;
            pend_vec_q <= '0;
            pend_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_vec_q <= pend_vec_d;
            pend_q     <= pend_d;
            fault_q    <= fault_d;
        end
    end

    pc_return_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (push),
        .i_pop      (pop),
        .i_data     (pc_q),
        .o_data     (pop_data),
        .o_empty    (o_stack_empty),
        .o_full     (o_stack_full),
        .o_overflow (ovf),
        .o_underflow(unf)
    );

`ifdef PC_BRANCH_TRACE_EN
    logic [ADDR_W-1:0] trace_src_q, trace_src_d, trace_dst_q, trace_dst_d;
    logic              jump;

    assign o_trace_src = trace_src_q;
    assign o_trace_dst = trace_dst_q;

    // capture old and new PC on every non-sequential change
    always_comb begin
        jump        = (op == OP_PEND) || (op == OP_INT) || (op == OP_RET) || (op == OP_SET);
        trace_src_d = jump ? pc_q : trace_src_q;
        trace_dst_d = jump ? pc_d : trace_dst_q;
    end

    // trace registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            trace_src_q <= '0;
            trace_dst_q <= '0;
        end else begin
            trace_src_q <= trace_src_d;
            trace_dst_q <= trace_dst_d;
        end
    end
`endif
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed plan plus random strobes checked against a queue-based model every cycle
module tb_program_counter;
    import pc_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = RESET_VECTOR_DEF;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] r_a = '0;
    logic        r_set = 0, r_ae = 0, r_lk = 0, r_int = 0, r_ret = 0, r_adv = 0;
    logic [15:0] o_addr_bus, o_pc;
    logic        o_addr_oe, o_stack_empty, o_stack_full, o_fault;
`ifdef PC_BRANCH_TRACE_EN
    logic [15:0] o_trace_src, o_trace_dst;
    logic [15:0] m_src = '0, m_dst = '0;
`endif

    logic [15:0] m_pc = RV;
    logic [15:0] m_q[$];
    logic        m_pend = 0;
    logic [15:0] m_vec = '0;
    logic        m_fault = 0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    program_counter dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_load_addr     (r_a),
        .i_set_enable    (r_set),
        .i_address_enable(r_ae),
        .i_lock          (r_lk),
        .i_interrupt     (r_int),
        .i_ret           (r_ret),
        .i_advance       (r_adv),
        .o_addr_bus      (o_addr_bus),
        .o_addr_oe       (o_addr_oe),
        .o_pc            (o_pc),
        .o_stack_empty   (o_stack_empty),
        .o_stack_full    (o_stack_full),
`ifdef PC_BRANCH_TRACE_EN
        .o_trace_src     (o_trace_src),
        .o_trace_dst     (o_trace_dst),
`endif
        .o_fault         (o_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = RV; m_q = {}; m_pend = 0; m_vec = '0; m_fault = 0;
`ifdef PC_BRANCH_TRACE_EN
        m_src = '0; m_dst = '0;
`endif
    endtask

    task automatic m_jump(input logic [15:0] nxt);
`ifdef PC_BRANCH_TRACE_EN
        m_src = m_pc; m_dst = nxt;
`endif
        m_pc = nxt;
    endtask

    task automatic m_push();
        if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_fault = 1;
        end
        m_q.push_back(m_pc);
    endtask

    task automatic m_step();
        if (r_lk) begin
            if (r_int) begin m_pend = 1; m_vec = r_a; end
        end else if (m_pend) begin
            m_push(); m_jump(m_vec); m_pend = 0;
        end else if (r_int) begin
            m_push(); m_jump(r_a);
        end else if (r_ret) begin
            if (m_q.size() == 0) begin m_fault = 1; m_jump(RV); end
            else m_jump(m_q.pop_back());
        end else if (r_set) m_jump(r_a);
        else if (r_adv) m_pc = m_pc + 16'd1;
    endtask

    // one cycle: drive strobes just after a falling edge, let the rising edge take them, advance the model
    task automatic cyc(input logic [15:0] a, input logic set, lk, intr, ret, adv, ae = 1'b1);
        r_a = a; r_set = set; r_lk = lk; r_int = intr; r_ret = ret; r_adv = adv; r_ae = ae;
        @(posedge clk);
        m_step();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        n_rst = 0;
        m_reset();
        r_set = 0; r_lk = 0; r_int = 0; r_ret = 0; r_adv = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_rst = 1;
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("pc", {16'd0, o_pc}, {16'd0, m_pc});
        chk("empty", {31'd0, o_stack_empty}, {31'd0, m_q.size() == 0});
        chk("full", {31'd0, o_stack_full}, {31'd0, m_q.size() == DEPTH});
        chk("fault", {31'd0, o_fault}, {31'd0, m_fault});
        chk("oe", {31'd0, o_addr_oe}, {31'd0, r_ae});
        chk("bus", {16'd0, o_addr_bus}, {16'd0, r_ae ? m_pc : 16'h0000});
`ifdef PC_BRANCH_TRACE_EN
        chk("tsrc", {16'd0, o_trace_src}, {16'd0, m_src});
        chk("tdst", {16'd0, o_trace_dst}, {16'd0, m_dst});
`endif
    end

    initial begin
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("lit_rst_pc", {16'd0, o_pc}, 32'h0000);
        chk("lit_rst_empty", {31'd0, o_stack_empty}, 32'd1);
        chk("lit_rst_fault", {31'd0, o_fault}, 32'd0);
        n_rst = 1;
        cyc(16'h0, 0, 0, 0, 0, 1); chk("lit_adv1", {16'd0, o_pc}, 32'h0001);
        cyc(16'h0, 0, 0, 0, 0, 1); chk("lit_adv2", {16'd0, o_pc}, 32'h0002);
        cyc(16'h0, 0, 0, 0, 0, 1); chk("lit_adv3", {16'd0, o_pc}, 32'h0003);
        cyc(16'hFFFF, 1, 0, 0, 0, 0);
        cyc(16'h0, 0, 0, 0, 0, 1); chk("lit_wrap", {16'd0, o_pc}, 32'h0000);
        cyc(16'h0100, 1, 0, 0, 0, 0);
        cyc(VEC_A, 0, 0, 1, 0, 0); chk("lit_int", {16'd0, o_pc}, 32'hFDA9);
        chk("lit_int_empty", {31'd0, o_stack_empty}, 32'd0);
        cyc(16'h0, 0, 0, 0, 1, 0); chk("lit_ret", {16'd0, o_pc}, 32'h0100);
        chk("lit_ret_empty", {31'd0, o_stack_empty}, 32'd1);
        cyc(VEC_B, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(16'h0, 0, 1, 0, 0, 1);
        chk("lit_lock_hold", {16'd0, o_pc}, 32'h0100);
        cyc(16'h0, 0, 0, 0, 0, 1); chk("lit_pend", {16'd0, o_pc}, 32'hFB53);
        cyc(16'h0, 0, 0, 0, 1, 0); chk("lit_pend_ret", {16'd0, o_pc}, 32'h0100);
        cyc(16'h1234, 1, 0, 1, 0, 0);
        r_a = VEC_A;
        cyc(VEC_A, 1, 0, 1, 0, 0); chk("lit_int_over_set", {16'd0, o_pc}, 32'hFDA9);
        cyc(16'h0, 0, 0, 0, 1, 1); chk("lit_ret_over_adv", {16'd0, o_pc}, 32'h1234);
        cyc(16'h0, 0, 0, 0, 1, 0); chk("lit_ret2", {16'd0, o_pc}, 32'h0100);
        for (int i = 0; i <= DEPTH; i++) cyc(16'h1000 + 16'(i), 0, 0, 1, 0, 0);
        chk("lit_full", {31'd0, o_stack_full}, 32'd1);
        chk("lit_ovf_fault", {31'd0, o_fault}, 32'd1);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cyc(16'h0, 0, 0, 0, 1, 0);
            chk("lit_unwind", {16'd0, o_pc}, 32'h1000 + 32'(i));
        end
        cyc(16'h0, 0, 0, 0, 1, 0); chk("lit_underflow", {16'd0, o_pc}, {16'd0, RV});
        cyc(16'h0, 0, 0, 0, 0, 0, 0); chk("lit_bus_off", {16'd0, o_addr_bus}, 32'h0000);
        cyc(16'h0, 0, 0, 0, 0, 0, 1); chk("lit_bus_on", {16'd0, o_addr_bus}, {16'd0, o_pc});
        cyc(16'h0200, 1, 0, 0, 0, 0);
        cyc(VEC_B, 0, 1, 1, 0, 0);
        rst_pulse();
        cyc(16'h0, 0, 0, 0, 0, 0);
        cyc(16'h0, 0, 0, 0, 0, 0);
        chk("lit_rst_pend", {16'd0, o_pc}, {16'd0, RV});
        chk("lit_rst_pend_empty", {31'd0, o_stack_empty}, 32'd1);
        chk("lit_rst_fault_clr", {31'd0, o_fault}, 32'd0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) rst_pulse();
            else cyc(16'($urandom), $urandom_range(99) < 15, $urandom_range(99) < 15,
                     $urandom_range(99) < 12, $urandom_range(99) < 18,
                     $urandom_range(99) < 50, 1'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
